// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one command at a time to a combinational ALU, waits SETTLE
// cycles, captures R/flag and returns them over a valid/ready response port.
module alu_op_sequencer #(
  parameter int WIDTH  = 6,
  parameter int OP_W   = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_flag,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  localparam int CW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] last_r;
  logic accept, done, release_rsp;
  assign cmd_ready   = state == IDLE;
  assign busy        = state != IDLE;
  assign accept      = cmd_valid && cmd_ready;
  assign done        = state == WAIT && cnt == CW'(1);
  assign release_rsp = state == RESP && rsp_valid && rsp_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = accept ? WAIT : done ? RESP : release_rsp ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      cnt       <= '0;
      last_r    <= '0;
      rsp_valid <= 1'b0;
      rsp_r     <= '0;
      rsp_flag  <= 1'b0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        alu_a  <= cmd_chain ? last_r : cmd_a;
        alu_b  <= cmd_b;
        alu_op <= cmd_op;
        cnt    <= CW'(SETTLE);
      end
      if (state == WAIT) cnt <= cnt - CW'(1);
      // ALU outputs are sampled only on the final settle edge
      if (done) begin
        rsp_r     <= alu_r;
        rsp_flag  <= alu_flag;
        last_r    <= alu_r;
        rsp_valid <= 1'b1;
        op_count  <= op_count + CNT_W'(1);
      end
      if (release_rsp) rsp_valid <= 1'b0;
    end
endmodule
